// File: rtl/current_sample_sched_pkg.sv
// Shared types and constants for the phase-current sample scheduler.
// State encoding is one-hot; saturation uses two guard bits above DATA_WIDTH.
package current_sample_sched_pkg;

  localparam int unsigned CSS_DATA_WIDTH     = 16;
  localparam int unsigned CSS_TIMEOUT_CYCLES = 2000;
  localparam int unsigned SAT_GUARD_BITS     = 2;
  localparam int unsigned ERR_CNT_W          = 4;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef enum logic [7:0] {
    ST_IDLE    = 8'b0000_0001,
    ST_START_A = 8'b0000_0010,
    ST_WAIT_A  = 8'b0000_0100,
    ST_START_B = 8'b0000_1000,
    ST_WAIT_B  = 8'b0001_0000,
    ST_WAIT_AB = 8'b0010_0000,
    ST_CALC    = 8'b0100_0000,
    ST_REPORT  = 8'b1000_0000
  } state_e;

  // Per-sensor result record used when both PHYs run concurrently.
  typedef struct packed {
    logic seen;
    logic ok;
  } sensor_flag_t;

endpackage

// File: rtl/current_sample_sched_timeout_cnt.sv
// Load/run/expire counter bounding how long a PHY may take to answer.
module sched_timeout_cnt
  import current_sample_sched_pkg::*;
#(
  parameter int unsigned LIMIT = CSS_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load_in,
  input  logic run_in,
  output logic expired_out
);

  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_in) begin
      cnt_d = '0;
    end else if (run_in && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_out = run_in && (cnt_q == LAST);

endmodule

// File: rtl/current_sample_sched.sv
// Per-PWM-period scheduler for two phase-current PHYs: launches detects,
// collects results with a timeout, derives ic and escalates repeated failures.
module current_sample_sched
  import current_sample_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = CSS_DATA_WIDTH,
  parameter int unsigned SHARED_BUS     = 1,
  parameter int unsigned TIMEOUT_CYCLES = CSS_TIMEOUT_CYCLES,
  parameter int unsigned ERR_LIMIT      = 3
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  enable_in,
  input  logic                  trigger_in,
  input  logic                  clear_fault_in,
  output logic                  det_en_a_out,
  output logic                  det_en_b_out,
  input  logic                  done_a_in,
  input  logic                  done_b_in,
  input  logic                  err_a_in,
  input  logic                  err_b_in,
  input  logic [DATA_WIDTH-1:0] cur_a_in,
  input  logic [DATA_WIDTH-1:0] cur_b_in,
  output logic [DATA_WIDTH-1:0] ia_out,
  output logic [DATA_WIDTH-1:0] ib_out,
  output logic [DATA_WIDTH-1:0] ic_out,
  output logic                  sample_valid_out,
  output logic                  sample_err_out,
  output logic                  overrun_out,
  output logic                  fault_out,
  output logic                  busy_out
);

  localparam int unsigned SW = DATA_WIDTH + SAT_GUARD_BITS;
  localparam logic signed [SW-1:0] SAT_HI = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {3'b111, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ERR_CNT_W-1:0] ERR_LIMIT_C = ERR_CNT_W'(ERR_LIMIT);

  state_e                state_q, state_d;
  sensor_flag_t          flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic [DATA_WIDTH-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic [DATA_WIDTH-1:0] ia_q, ia_d, ib_q, ib_d, ic_q, ic_d;
  logic                  good_q, good_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  fault_q, fault_d;
  logic                  overrun_q, overrun_d;

  logic                  to_load, to_run, to_expired;
  logic                  fail_evt, pass_evt;
  logic signed [SW-1:0]  sum_w, neg_w;
  logic [DATA_WIDTH-1:0] ic_sat;

  sched_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (sys_clk),
    .rst        (reset),
    .load_in    (to_load),
    .run_in     (to_run),
    .expired_out(to_expired)
  );

  // Negating a (DATA_WIDTH+1)-bit sum can itself overflow, so two guard bits are kept.
  always_comb begin
    sum_w = {{SAT_GUARD_BITS{cap_a_q[DATA_WIDTH-1]}}, cap_a_q}
          + {{SAT_GUARD_BITS{cap_b_q[DATA_WIDTH-1]}}, cap_b_q};
    neg_w = -sum_w;
    if (neg_w > SAT_HI) begin
      ic_sat = SAT_HI[DATA_WIDTH-1:0];
    end else if (neg_w < SAT_LO) begin
      ic_sat = SAT_LO[DATA_WIDTH-1:0];
    end else begin
      ic_sat = neg_w[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    cap_a_d  = cap_a_q;
    cap_b_d  = cap_b_q;
    ia_d     = ia_q;
    ib_d     = ib_q;
    ic_d     = ic_q;
    good_d   = good_q;
    to_load  = 1'b0;
    to_run   = 1'b0;
    fail_evt = 1'b0;
    pass_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trigger_in && enable_in && !fault_q) begin
          state_d = ST_START_A;
        end
      end
      ST_START_A: begin
        to_load  = 1'b1;
        flag_a_d = '0;
        flag_b_d = '0;
        state_d  = (SHARED_BUS != 0) ? ST_WAIT_A : ST_WAIT_AB;
      end
      ST_WAIT_A: begin
        to_run = 1'b1;
        if (err_a_in) begin
          fail_evt = 1'b1;
        end else if (done_a_in) begin
          cap_a_d = cur_a_in;
          state_d = ST_START_B;
        end else if (to_expired) begin
          fail_evt = 1'b1;
        end
      end
      ST_START_B: begin
        to_load = 1'b1;
        state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        to_run = 1'b1;
        if (err_b_in) begin
          fail_evt = 1'b1;
        end else if (done_b_in) begin
          cap_b_d = cur_b_in;
          state_d = ST_CALC;
        end else if (to_expired) begin
          fail_evt = 1'b1;
        end
      end
      ST_WAIT_AB: begin
        to_run = 1'b1;
        if (!flag_a_q.seen && (done_a_in || err_a_in)) begin
          flag_a_d.seen = 1'b1;
          flag_a_d.ok   = !err_a_in;
          if (!err_a_in) cap_a_d = cur_a_in;
        end
        if (!flag_b_q.seen && (done_b_in || err_b_in)) begin
          flag_b_d.seen = 1'b1;
          flag_b_d.ok   = !err_b_in;
          if (!err_b_in) cap_b_d = cur_b_in;
        end
        // A result landing on the expiry cycle still counts.
        if (flag_a_d.seen && flag_b_d.seen) begin
          if (flag_a_d.ok && flag_b_d.ok) begin
            state_d = ST_CALC;
          end else begin
            fail_evt = 1'b1;
          end
        end else if (to_expired) begin
          fail_evt = 1'b1;
        end
      end
      ST_CALC: begin
        pass_evt = 1'b1;
        ia_d     = cap_a_q;
        ib_d     = cap_b_q;
        ic_d     = ic_sat;
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail_evt) begin
      state_d = ST_REPORT;
      good_d  = 1'b0;
    end
    if (pass_evt) begin
      state_d = ST_REPORT;
      good_d  = 1'b1;
    end
  end

  // Counter and fault settle on entry to REPORT so fault_out rises with sample_err_out.
  always_comb begin
    err_cnt_d = err_cnt_q;
    fault_d   = fault_q;
    if (clear_fault_in) begin
      err_cnt_d = '0;
      fault_d   = 1'b0;
    end
    if (pass_evt) begin
      err_cnt_d = '0;
    end
    if (fail_evt) begin
      if (err_cnt_d != ERR_CNT_MAX) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
      if (err_cnt_d == ERR_LIMIT_C) fault_d = 1'b1;
    end
    overrun_d = trigger_in && ((state_q != ST_IDLE) || fault_q);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      flag_a_q  <= '0;
      flag_b_q  <= '0;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
      ia_q      <= '0;
      ib_q      <= '0;
      ic_q      <= '0;
      good_q    <= 1'b0;
      err_cnt_q <= '0;
      fault_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flag_a_q  <= flag_a_d;
      flag_b_q  <= flag_b_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      ia_q      <= ia_d;
      ib_q      <= ib_d;
      ic_q      <= ic_d;
      good_q    <= good_d;
      err_cnt_q <= err_cnt_d;
      fault_q   <= fault_d;
      overrun_q <= overrun_d;
    end
  end

  assign det_en_a_out     = (state_q == ST_START_A);
  assign det_en_b_out     = (state_q == ST_START_B) || ((SHARED_BUS == 0) && (state_q == ST_START_A));
  assign ia_out           = ia_q;
  assign ib_out           = ib_q;
  assign ic_out           = ic_q;
  assign sample_valid_out = (state_q == ST_REPORT) && good_q;
  assign sample_err_out   = (state_q == ST_REPORT) && !good_q;
  assign overrun_out      = overrun_q;
  assign fault_out        = fault_q;
  assign busy_out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_current_sample_sched.sv
// Bench for current_sample_sched: instance 0 runs the shared-bus sequence,
// instance 1 launches both PHYs together; reactive PHY models answer det_en pulses.
`timescale 1ns/1ps
module tb_current_sample_sched;

  localparam int unsigned DW  = 16;
  localparam int unsigned TO  = 24;
  localparam int unsigned LIM = 3;
  localparam int K_DONE = 0, K_ERR = 1, K_SILENT = 2, K_BOTH = 3;

  typedef struct { int kind; int dly; int val; } phy_t;
  typedef struct { int d; phy_t a; phy_t b; bit good; int ic; } vec_t;
  typedef struct { bit good; int rep; int enb; int nb; } outcome_t;

  logic clk = 1'b0;
  logic rst;
  logic en[2], trig[2], clr[2], det_a[2], det_b[2];
  logic done_a[2], done_b[2], err_a[2], err_b[2];
  logic [DW-1:0] cur_a[2], cur_b[2], ia[2], ib[2], ic[2];
  logic valid[2], serr[2], ovr[2], fault[2], busy[2];

  int checks = 0;
  int errors = 0;
  int m_errs[2], m_ia[2], m_ib[2], m_ic[2];
  bit m_fault[2];
  vec_t tbl[8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    current_sample_sched #(
      .DATA_WIDTH(DW), .SHARED_BUS((g == 0) ? 1 : 0), .TIMEOUT_CYCLES(TO), .ERR_LIMIT(LIM)
    ) u_dut (
      .sys_clk(clk), .reset(rst), .enable_in(en[g]), .trigger_in(trig[g]),
      .clear_fault_in(clr[g]), .det_en_a_out(det_a[g]), .det_en_b_out(det_b[g]),
      .done_a_in(done_a[g]), .done_b_in(done_b[g]), .err_a_in(err_a[g]), .err_b_in(err_b[g]),
      .cur_a_in(cur_a[g]), .cur_b_in(cur_b[g]), .ia_out(ia[g]), .ib_out(ib[g]), .ic_out(ic[g]),
      .sample_valid_out(valid[g]), .sample_err_out(serr[g]), .overrun_out(ovr[g]),
      .fault_out(fault[g]), .busy_out(busy[g])
    );
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic phy_t rand_phy();
    phy_t p;
    int r = $urandom_range(0, 99);
    p.kind = (r < 72) ? K_DONE : (r < 82) ? K_ERR : (r < 90) ? K_BOTH : K_SILENT;
    p.dly  = $urandom_range(1, TO);
    p.val  = int'($urandom_range(0, 65535)) - 32768;
    return p;
  endfunction

  // Cycle 0 = trigger, cycle 1 = first detect enable; a PHY answers dly cycles after its enable.
  function automatic outcome_t predict(input int d, input phy_t a, input phy_t b);
    outcome_t o;
    int last;
    o.good = 1'b0; o.enb = -1; o.nb = 0; o.rep = 0;
    if (d == 0) begin
      if (a.kind == K_SILENT) o.rep = 1 + TO + 1;
      else if (a.kind != K_DONE) o.rep = 1 + a.dly + 1;
      else begin
        o.enb = 1 + a.dly + 1;
        o.nb  = 1;
        if (b.kind == K_SILENT) o.rep = o.enb + TO + 1;
        else if (b.kind != K_DONE) o.rep = o.enb + b.dly + 1;
        else begin o.rep = o.enb + b.dly + 2; o.good = 1'b1; end
      end
    end else begin
      o.enb = 1;
      o.nb  = 1;
      if (a.kind == K_SILENT || b.kind == K_SILENT) o.rep = 1 + TO + 1;
      else begin
        last   = 1 + ((a.dly > b.dly) ? a.dly : b.dly);
        o.good = (a.kind == K_DONE) && (b.kind == K_DONE);
        o.rep  = last + (o.good ? 2 : 1);
      end
    end
    return o;
  endfunction

  task automatic run_sample(input int d, input phy_t a, input phy_t b, input int xtrig,
                            output bit got_good);
    outcome_t o;
    int na = 0, nb = 0, ena = -1, enb = -1, vc = -1, ec = -1, oc = -1;
    int novr = 0, nv = 0, ne = 0, xt;
    bit flt = 1'b0, hit_a, hit_b;
    if (m_fault[d]) begin
      clr[d] = 1'b1; tick(); clr[d] = 1'b0; tick();
      m_fault[d] = 1'b0; m_errs[d] = 0;
    end
    o  = predict(d, a, b);
    xt = xtrig;
    if (xt < 0) xt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, o.rep)) : 0;
    for (int k = 0; k < 2 * TO + 12; k++) begin
      if (det_a[d]) begin na++; ena = k; end
      if (det_b[d]) begin nb++; enb = k; end
      if (valid[d]) begin nv++; vc = k; flt = fault[d]; end
      if (serr[d])  begin ne++; ec = k; flt = fault[d]; end
      if (ovr[d])   begin novr++; oc = k; end
      if ((vc >= 0 || ec >= 0) && k >= o.rep + 3) break;
      hit_a = (ena >= 0) && (k == ena + a.dly);
      hit_b = (enb >= 0) && (k == enb + b.dly);
      trig[d]   = (k == 0) || (k == xt);
      done_a[d] = hit_a && (a.kind == K_DONE || a.kind == K_BOTH);
      err_a[d]  = hit_a && (a.kind == K_ERR || a.kind == K_BOTH);
      done_b[d] = hit_b && (b.kind == K_DONE || b.kind == K_BOTH);
      err_b[d]  = hit_b && (b.kind == K_ERR || b.kind == K_BOTH);
      cur_a[d]  = done_a[d] ? DW'(a.val) : DW'($urandom);
      cur_b[d]  = done_b[d] ? DW'(b.val) : DW'($urandom);
      tick();
    end
    trig[d] = 1'b0; done_a[d] = 1'b0; err_a[d] = 1'b0; done_b[d] = 1'b0; err_b[d] = 1'b0;

    if (o.good) begin
      m_ia[d] = a.val; m_ib[d] = b.val; m_ic[d] = sat16(-(a.val + b.val)); m_errs[d] = 0;
    end else begin
      if (m_errs[d] < 15) m_errs[d]++;
      if (m_errs[d] == LIM) m_fault[d] = 1'b1;
    end
    check($sformatf("d%0d det_a count", d), na, 1);
    check($sformatf("d%0d det_a cycle", d), ena, 1);
    check($sformatf("d%0d det_b count", d), nb, o.nb);
    if (o.nb == 1) check($sformatf("d%0d det_b cycle", d), enb, o.enb);
    check($sformatf("d%0d valid count", d), nv, o.good ? 1 : 0);
    check($sformatf("d%0d err count", d), ne, o.good ? 0 : 1);
    check($sformatf("d%0d report cycle", d), o.good ? vc : ec, o.rep);
    check($sformatf("d%0d overrun count", d), novr, (xt > 0) ? 1 : 0);
    if (xt > 0) check($sformatf("d%0d overrun cycle", d), oc, xt + 1);
    check($sformatf("d%0d fault at report", d), flt, m_fault[d]);
    check($sformatf("d%0d ia", d), $signed(ia[d]), m_ia[d]);
    check($sformatf("d%0d ib", d), $signed(ib[d]), m_ib[d]);
    check($sformatf("d%0d ic", d), $signed(ic[d]), m_ic[d]);
    check($sformatf("d%0d busy after", d), busy[d], 0);
    got_good = (nv == 1);
  endtask

  task automatic check_zero(input string nm, input int d);
    check({nm, " ctl"}, {det_a[d], det_b[d], valid[d], serr[d], ovr[d], fault[d], busy[d]}, 0);
    check({nm, " data"}, {ia[d], ib[d], ic[d]}, 0);
  endtask

  initial begin
    bit gg;
    int bad;
    phy_t pa, pb;

    tbl[0] = '{0, '{K_DONE, 3, 120},     '{K_DONE, 2, -50},    1'b1, -70};
    tbl[1] = '{1, '{K_DONE, 5, 300},     '{K_DONE, 2, 400},    1'b1, -700};
    tbl[2] = '{0, '{K_DONE, 1, -32768},  '{K_DONE, 1, -32768}, 1'b1, 32767};
    tbl[3] = '{1, '{K_DONE, TO, 32767},  '{K_DONE, 1, 32767},  1'b1, -32768};
    tbl[4] = '{0, '{K_SILENT, 1, 5},     '{K_DONE, 1, 6},      1'b0, 32767};
    tbl[5] = '{1, '{K_BOTH, 4, 7},       '{K_DONE, 2, 8},      1'b0, -32768};
    tbl[6] = '{0, '{K_DONE, 2, 1000},    '{K_ERR, 3, 9},       1'b0, 32767};
    tbl[7] = '{0, '{K_DONE, 2, 0},       '{K_DONE, TO, 0},     1'b1, 0};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b1; trig[i] = 1'b0; clr[i] = 1'b0;
      done_a[i] = 1'b0; done_b[i] = 1'b0; err_a[i] = 1'b0; err_b[i] = 1'b0;
      cur_a[i] = '0; cur_b[i] = '0;
      m_errs[i] = 0; m_ia[i] = 0; m_ib[i] = 0; m_ic[i] = 0; m_fault[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_zero("reset d0", 0);
    check_zero("reset d1", 1);

    for (int i = 0; i < 8; i++) begin
      run_sample(tbl[i].d, tbl[i].a, tbl[i].b, 0, gg);
      check($sformatf("tbl%0d good", i), gg, tbl[i].good);
      check($sformatf("tbl%0d ic", i), $signed(ic[tbl[i].d]), tbl[i].ic);
    end

    // Enable low: trigger ignored without an overrun.
    en[0] = 1'b0; trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    bad = 0;
    repeat (4) begin bad += int'(busy[0]) + int'(ovr[0]) + int'(det_a[0]); tick(); end
    check("disabled trigger ignored", bad, 0);
    en[0] = 1'b1;

    // Trigger while in WAIT_B: enable_b at 4, WAIT_B from 5.
    pa = '{K_DONE, 2, 10}; pb = '{K_DONE, 6, 20};
    run_sample(0, pa, pb, 6, gg);

    // Three consecutive A errors latch the fault, then triggers overrun until cleared.
    pa = '{K_ERR, 3, 0};
    for (int i = 0; i < 3; i++) run_sample(0, pa, pb, 0, gg);
    check("fault latched", fault[0], 1);
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    check("overrun while faulted", ovr[0], 1);
    check("no start while faulted", {busy[0], det_a[0]}, 0);
    tick();
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    check("fault cleared", fault[0], 0);
    m_fault[0] = 1'b0; m_errs[0] = 0;
    pa = '{K_DONE, 4, -1234}; pb = '{K_DONE, 3, 555};
    run_sample(0, pa, pb, 0, gg);
    check("accepted after clear", gg, 1);

    for (int n = 0; n < 40; n++) begin
      run_sample(int'($urandom_range(0, 1)), rand_phy(), rand_phy(), -1, gg);
    end

    // Reset asserted while waiting on PHY A abandons the sample.
    pa = '{K_DONE, 2, 111}; pb = '{K_DONE, 2, 222};
    run_sample(0, pa, pb, 0, gg);
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    tick(); tick();
    check("in WAIT_A before reset", busy[0], 1);
    #2 rst = 1'b1;
    #1;
    check_zero("mid-sample reset d0", 0);
    check_zero("mid-sample reset d1", 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_errs[i] = 0; m_ia[i] = 0; m_ib[i] = 0; m_ic[i] = 0; m_fault[i] = 1'b0;
    end
    tick();
    check_zero("after reset d0", 0);
    pa = '{K_DONE, 3, 77}; pb = '{K_DONE, 1, -88};
    run_sample(0, pa, pb, 0, gg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
